mat_mac_engine: RTL
===================

Name: mat_mac_engine

Overview:
Parametrised, sequential N×N unsigned matrix multiply-accumulate engine computing R = A×B + C with selectable wrap or saturate output. Generalises the fixed 2×2 combinational stage to arbitrary N and WIDTH. Adds valid/ready handshakes, a k-loop accumulation over N cycles, and an overflow flag. Chains into the matrix datapath: two instances in series give (A×B+C)×D+E.

Parameters:
N, 2, matrix dimension (N≥2)
WIDTH, 8, element width in bits (unsigned)
ACC_W, 2*WIDTH+$clog2(N)+1, internal accumulator width (derived; not overridden)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operand set valid
in_ready  output  1  engine can accept an operand set
A  input  N*N*WIDTH  matrix A, packed
B  input  N*N*WIDTH  matrix B, packed
C  input  N*N*WIDTH  addend matrix C, packed
sat_mode  input  1  0 = wrap (truncate to WIDTH), 1 = saturate to 2^WIDTH-1
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
Res  output  N*N*WIDTH  result matrix R, packed
out_ovf  output  1  at least one element exceeded 2^WIDTH-1 before wrap/saturate
busy  output  1  state != IDLE

Behaviour:
- Packing: element (i,j) occupies bits [(N*N-1-(i*N+j))*WIDTH +: WIDTH]. Row-major, (0,0) in the MSBs. Same packing for A, B, C and Res.
- Reset (async, immediate): state=IDLE, k=0, accumulators=0, Res=0, out_valid=0, out_ovf=0. in_ready=1 and busy=0 follow from IDLE.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE). out_valid is registered, high only in DONE.
- IDLE:
  - On the edge where in_valid && in_ready: register A, B and sat_mode; preload acc[i][j] with zero-extended C[i][j]; k←0; go to RUN.
  - Without in_valid, hold state.
- RUN: each edge, acc[i][j] += A[i][k]*B[k][j] for all i,j in parallel (N*N multipliers); k←k+1.
  - On the edge where k==N-1, include the last product, then:
    - Register Res[i][j] = sat_mode ? min(acc,2^WIDTH-1) : acc[WIDTH-1:0].
    - Register out_ovf = OR over all elements of (acc > 2^WIDTH-1).
    - Set out_valid=1 and go to DONE.
- Latency: out_valid rises exactly N clock edges after the accepting edge.
- DONE:
  - Res and out_ovf hold stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid←0, go to IDLE.
  - Res and out_ovf keep their last value until overwritten.
- Throughput: one operand set per N+2 cycles with out_ready held high. No acceptance while RUN/DONE.
- Arithmetic: all operands unsigned. ACC_W guarantees no accumulator overflow. Wrap mode matches the legacy stage (low WIDTH bits kept).
- Boundaries:
  - in_valid asserted in RUN/DONE is ignored; the upstream must hold it until in_ready.
  - Input changes after acceptance do not affect the result.
  - out_ready high outside DONE has no effect.
  - Reset during RUN or DONE aborts: the result is lost and no out_valid is produced.
  - sat_mode is sampled only at acceptance.

Decomposition:
- Package mat_pkg:
  - state enum {IDLE,RUN,DONE}
  - function acc_width(N,WIDTH)
  - function elem_lsb(i,j,N,WIDTH) for packing
  - function sat_trunc(acc,sat_mode,WIDTH)
- Sub-module mat_mac_pe: one cell holding acc[i][j]. Ports:
  - clear/preload with C
  - accumulate enable with a×b
  - outputs: truncated/saturated value and overflow bit
- Top generates N*N PEs, plus the k counter, FSM and operand registers.

Test Plan:
1. N=2, W=8, A={1,2,3,4}, B={1,2,3,4}, C=all 1, sat_mode=0 -> Res={8,11,16,23}, out_ovf=0, out_valid 2 edges after acceptance.
2. N=2, W=8, A=B=all 255, C=0 -> sat_mode=1: Res all 255, out_ovf=1; sat_mode=0: Res all 0x02 (130050 mod 256), out_ovf=1.
3. Backpressure: after out_valid, hold out_ready=0 for 5 cycles while toggling A/B and asserting in_valid -> Res stable, in_ready=0, no acceptance. out_ready=1 -> one handshake, then IDLE.
4. N=4, W=16, B=identity, C=0, A random -> Res==A, out_ovf=0, out_valid 4 edges after acceptance.
5. Reset asserted mid-RUN (k=1) -> immediately out_valid=0, Res=0, busy=0, in_ready=1. A following operand set computes correctly with no residue from the aborted one.
6. Back-to-back: in_valid and out_ready held high over three sets -> acceptances spaced N+2 cycles apart, each Res correct and in order.

Source files
------------

// File: rtl/mat_pkg.sv
// Shared types and helpers for the N x N multiply-accumulate engine.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mat_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    // Widest element the generic saturation helper handles.
    localparam int MAX_W     = 32;
    localparam int MAX_ACC_W = 2*MAX_W + 9;

    function automatic int acc_width(input int n, input int width);
        return 2*width + $clog2(n) + 1;
    endfunction

    // Row-major packing with element (0,0) in the MSBs.
    function automatic int elem_lsb(input int i, input int j, input int n, input int width);
        return (n*n - 1 - (i*n + j)) * width;
    endfunction

    function automatic logic [MAX_W-1:0] sat_trunc(input logic [MAX_ACC_W-1:0] acc,
                                                   input logic                 sat,
                                                   input int                   width);
        logic [MAX_ACC_W-1:0] lim;
        lim = (MAX_ACC_W'(1) << width) - MAX_ACC_W'(1);
        if (sat && (acc > lim)) begin
            return MAX_W'(lim);
        end
        return MAX_W'(acc & lim);
    endfunction

endpackage

// File: rtl/mat_mac_pe.sv
// One accumulator cell acc[i][j]: preload with C, then add one product per enabled cycle.
// Latency: result/overflow outputs reflect the accumulator value after the current edge.
// Backpressure: none; the engine FSM gates load and acc_en.
module mat_mac_pe
    import mat_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ACC_W = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] c_in,
    input  logic             acc_en,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             sat,
    output logic [WIDTH-1:0] res_nxt,
    output logic             ovf_nxt
);

    localparam int PW = 2*WIDTH;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [PW-1:0]    prod;

    always_comb begin
        prod  = PW'(a_in) * PW'(b_in);
        acc_d = acc_q;
        if (load) begin
            acc_d = ACC_W'(c_in);
        end else if (acc_en) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    // Exposing the next value lets the engine capture the final sum on the last k edge.
    assign res_nxt = WIDTH'(sat_trunc(MAX_ACC_W'(acc_d), sat, WIDTH));
    assign ovf_nxt = |(acc_d >> WIDTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/mat_mac_engine.sv
// Sequential N x N unsigned R = A*B + C with wrap or saturate output and overflow flag.
// Latency: out_valid rises N edges after the accepting edge; one set per N+2 cycles.
// Backpressure: in_ready only in IDLE; Res/out_ovf held in DONE until out_ready.
module mat_mac_engine
    import mat_pkg::*;
#(
    parameter int N     = 2,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*N*WIDTH-1:0]   A,
    input  logic [N*N*WIDTH-1:0]   B,
    input  logic [N*N*WIDTH-1:0]   C,
    input  logic                   sat_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N*N*WIDTH-1:0]   Res,
    output logic                   out_ovf,
    output logic                   busy
);

    localparam int ACC_W = acc_width(N, WIDTH);
    localparam int KW    = $clog2(N);
    localparam int VW    = N*N*WIDTH;

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [VW-1:0]   a_q, a_d, b_q, b_d;
    logic [VW-1:0]   res_q, res_d;
    logic            sat_q, sat_d;
    logic            ovf_q, ovf_d;
    logic            out_vld_q, out_vld_d;
    logic            load, acc_en;
    logic [VW-1:0]   res_all;
    logic [N*N-1:0]  ovf_all;
    logic [WIDTH-1:0] a_m [N][N];
    logic [WIDTH-1:0] b_m [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                a_m[i][j] = a_q[elem_lsb(i, j, N, WIDTH) +: WIDTH];
                b_m[i][j] = b_q[elem_lsb(i, j, N, WIDTH) +: WIDTH];
            end
        end
    end

    // Each cell consumes column k of A's row i and row k of B's column j.
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            mat_mac_pe #(
                .WIDTH (WIDTH),
                .ACC_W (ACC_W)
            ) u_pe (
                .clk     (clk),
                .reset   (reset),
                .load    (load),
                .c_in    (C[elem_lsb(gi, gj, N, WIDTH) +: WIDTH]),
                .acc_en  (acc_en),
                .a_in    (a_m[gi][k_q]),
                .b_in    (b_m[k_q][gj]),
                .sat     (sat_q),
                .res_nxt (res_all[elem_lsb(gi, gj, N, WIDTH) +: WIDTH]),
                .ovf_nxt (ovf_all[gi*N + gj])
            );
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        a_d       = a_q;
        b_d       = b_q;
        sat_d     = sat_q;
        res_d     = res_q;
        ovf_d     = ovf_q;
        out_vld_d = out_vld_q;
        load      = 1'b0;
        acc_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    sat_d   = sat_mode;
                    load    = 1'b1;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_en = 1'b1;
                k_d    = k_q + KW'(1);
                if (k_q == KW'(N-1)) begin
                    res_d     = res_all;
                    ovf_d     = |ovf_all;
                    out_vld_d = 1'b1;
                    k_d       = '0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_vld_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                out_vld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            k_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sat_q     <= 1'b0;
            res_q     <= '0;
            ovf_q     <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sat_q     <= sat_d;
            res_q     <= res_d;
            ovf_q     <= ovf_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_vld_q;
    assign Res       = res_q;
    assign out_ovf   = ovf_q;

endmodule
